// File: rtl/sdram_stream_writer_pkg.sv
// Shared types, default widths and burst sizing helper for the SDRAM stream writer.
package sdram_writer_pkg;

  localparam int DATA_W_D     = 16;
  localparam int ADDR_W_D     = 32;
  localparam int LEN_W_D      = 24;
  localparam int FIFO_DEPTH_D = 16;
  localparam int BURST_LEN_D  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_t;

  // Size of the next burst: a full burst, or whatever is left of the transfer.
  function automatic logic [31:0] burst_of(input logic [31:0] remaining,
                                           input logic [31:0] max_len = 32'(BURST_LEN_D));
    if (remaining < max_len) begin
      burst_of = remaining;
    end else begin
      burst_of = max_len;
    end
  endfunction

endpackage

// File: rtl/sdram_stream_writer_fifo.sv
// First-word-fall-through synchronous FIFO buffering stream samples ahead of each burst.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array; pointers alone define what is valid, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_stream_writer.sv
// Avalon-MM burst write master draining a buffered sample stream into SDRAM.
module sdram_stream_writer
  import sdram_writer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_D,
  parameter int ADDR_W     = ADDR_W_D,
  parameter int LEN_W      = LEN_W_D,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D,
  parameter int BURST_LEN  = BURST_LEN_D
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [LEN_W-1:0]           length,
  output logic                       busy,
  output logic                       done,
  input  logic [DATA_W-1:0]          snk_data,
  input  logic                       snk_valid,
  output logic                       snk_ready,
  output logic [ADDR_W-1:0]          avm_address,
  output logic                       avm_write,
  output logic [DATA_W-1:0]          avm_writedata,
  output logic [DATA_W/8-1:0]        avm_byteenable,
  output logic [$clog2(BURST_LEN):0] avm_burstcount,
  input  logic                       avm_waitrequest
);

  localparam int BC_W  = $clog2(BURST_LEN) + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wr_state_t         r_state;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_accepted;
  logic [LEN_W-1:0]  r_written;
  logic [ADDR_W-1:0] r_addr;
  logic [BC_W-1:0]   r_bcnt;
  logic [BC_W-1:0]   r_beat;
  logic              r_busy;
  logic              r_done;

  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [DATA_W-1:0] w_head;
  logic [LEN_W-1:0]  w_remaining;
  logic [BC_W-1:0]   w_burst;
  logic              w_burst_ready;
  logic              w_last_beat;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .i_push  (w_push),
    .i_data  (snk_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Intake stops at the programmed length so excess samples stay upstream.
  assign snk_ready     = r_busy && !w_fifo_full && (r_accepted < r_len);
  assign w_push        = snk_valid && snk_ready;
  assign w_pop         = (r_state == ST_BURST) && !avm_waitrequest && !w_fifo_empty;
  assign w_remaining   = r_len - r_written;
  assign w_burst       = BC_W'(burst_of(32'(w_remaining), 32'(BURST_LEN)));
  assign w_burst_ready = (32'(w_fifo_count) >= 32'(w_burst));
  assign w_last_beat   = (r_beat == (r_bcnt - BC_W'(1)));

  assign busy           = r_busy;
  assign done           = r_done;
  assign avm_write      = (r_state == ST_BURST);
  assign avm_address    = r_addr;
  assign avm_burstcount = r_bcnt;
  assign avm_writedata  = w_head;
  assign avm_byteenable = '1;

  // Transfer control FSM with intake and write counters.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_accepted <= '0;
      r_written  <= '0;
      r_addr     <= '0;
      r_bcnt     <= '0;
      r_beat     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_push) begin
        r_accepted <= r_accepted + LEN_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (length != '0) begin
              r_base     <= base_addr & ~ADDR_W'(1);
              r_len      <= length;
              r_accepted <= '0;
              r_written  <= '0;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
              r_state    <= ST_FILL;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          // Address and size are frozen here so they stay stable for the whole burst.
          if (w_burst_ready) begin
            r_addr  <= r_base + (ADDR_W'(r_written) << 1);
            r_bcnt  <= w_burst;
            r_beat  <= '0;
            r_state <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (!avm_waitrequest) begin
            r_written <= r_written + LEN_W'(1);
            r_beat    <= r_beat + BC_W'(1);
            if (w_last_beat) begin
              if ((r_written + LEN_W'(1)) < r_len) begin
                r_state <= ST_FILL;
              end else begin
                r_state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
